conv3x3_8x8: RTL
================

Name: conv3x3_8x8

Overview:
- First convolutional stage of the CNN datapath. Convolves an 8x8 single-channel 8-bit image with a 3x3 signed kernel plus bias, using valid convolution with stride 1.
- Produces a 6x6 8-bit feature map, which is the exact input format of the downstream 2x2 max-pool stage.
- Computes one output pixel per cycle through a 2-stage pipeline. Raises done when the whole map is valid.

Parameters:
- SHIFT, default 4: arithmetic right-shift applied to the accumulator before saturation (fixed-point rescale).
- BIAS_W, default 16: width of the signed bias input.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  start request; sampled only in IDLE or DONE.
- image_in  input  512  unsigned pixel (r,c) at bits [8*(r*8+c) +: 8], r,c in 0..7.
- kernel_in  input  72  signed weight (kr,kc) at bits [8*(kr*3+kc) +: 8], kr,kc in 0..2.
- bias_in  input  BIAS_W  signed bias added to every output pixel.
- feature_out  output  288  output pixel (r,c) at bits [8*(r*6+c) +: 8], r,c in 0..5.
- busy  output  1  high from the start edge until done rises.
- done  output  1  high while feature_out holds a complete, valid map.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, feature_out=0, busy=0, done=0.
  - Pipeline registers, latched operands and index counter all cleared.
- States: IDLE, CONV, DONE.
- Start:
  - In IDLE or DONE, a rising edge with enable=1 latches image_in, kernel_in and bias_in into internal registers.
  - The same edge clears done, sets busy, clears idx to 0 and enters CONV.
  - Inputs may change freely after the start edge with no effect on the result.
- CONV:
  - Each edge issues output index idx (0..35), with r=idx/6 and c=idx%6.
  - Stage 1 registers acc = bias + sum over kr,kc of image[r+kr][c+kc] * kernel[kr][kc].
  - Widths: product is unsigned 8 x signed 8, giving signed 17 bits. The accumulator is signed 21 bits with the bias sign-extended. No overflow is possible at these widths.
  - Stage 2 registers sat(acc >>> SHIFT) into feature_out slot idx.
  - The idx=35 issue edge moves to DONE.
- Completion:
  - The stage-2 write of idx=35 happens on the edge that enters DONE+1.
  - done rises on that same edge, which is the 37th rising edge after the start edge. busy falls on that edge.
  - The state remains DONE. done stays high and feature_out stays stable until reset or the next start.
- feature_out slots not yet rewritten during a run keep their previous values. done=0 marks the whole map as invalid.
- enable while busy is ignored; no restart and no error.
- Start on the same edge as reset: reset wins.
- Reset mid-run: the run is aborted, done never rises, and the next start runs a full 37-cycle sequence.
- Saturation: see Optional Feature.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: ReLU plus unsigned saturate. A negative shifted value gives 0; a value above 255 gives 255; otherwise the low 8 bits are kept. feature_out is unsigned, which suits the unsigned comparisons in pooling.
- Undefined: signed saturate to [-128,127], two's complement in each 8-bit slot.

Test Plan:
- Reset held for 3 cycles with random inputs -> feature_out=0, busy=0, done=0. enable during reset is ignored.
- Image all 1, kernel all 1, bias 0, SHIFT=0 -> all 36 outputs =9. busy high on edges 1..36. done rises exactly on edge 37 after start.
- Image pixel (r,c)=r*8+c, kernel centre=1 with others 0, bias 0, SHIFT=0 -> out(r,c)=(r+1)*8+c+1. Checkpoints: out(0,0)=9, out(2,3)=28, out(5,5)=54.
- Image all 255, kernel all 127, SHIFT=4 -> acc=291465 >>> 4 = 18216, saturating to 255 with CONV_RELU_EN or 127 without. Kernel all -128 -> 0 with CONV_RELU_EN or -128 (0x80) without.
- Start, then change image_in and pulse enable at edge 10 -> result matches the originally latched image, and done rises only on edge 37.
- Reset asserted at edge 20 of a run -> done stays 0 and feature_out=0. A new start then completes correctly. A restart from DONE with a new image drops done on the start edge and re-raises it 37 edges later.

Source files
------------

// File: rtl/conv3x3_8x8.sv
// 3x3 valid convolution of an 8x8 image, one output per cycle, 2-stage pipe.
// Define CONV_RELU_EN for ReLU + unsigned saturation (else signed 8-bit).
module conv3x3_8x8 #(
  parameter int SHIFT  = 4,
  parameter int BIAS_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [511:0]      image_in,
  input  logic [71:0]       kernel_in,
  input  logic [BIAS_W-1:0] bias_in,
  output logic [287:0]      feature_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [511:0]              img_q;
  logic [71:0]               ker_q;
  logic signed [BIAS_W-1:0]  bias_q;
  logic [5:0]                idx;
  logic [2:0]                row, col;
  logic                      start;
  logic                      s1_vld;
  logic [5:0]                s1_idx;
  logic signed [20:0]        acc_d, acc_q;
  logic signed [20:0]        shv;
  logic [7:0]                sat;
  logic [7:0]                pix;
  logic signed [7:0]         w;
  logic signed [16:0]        prod;

  always_comb begin
    start   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        // busy stays high into DONE until the last write lands
        if (enable && !busy) begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (idx == 6'd35) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row = 3'(idx / 6'd6);
  assign col = 3'(idx % 6'd6);

  always_comb begin
    acc_d = 21'(bias_q);
    pix   = '0;
    w     = '0;
    prod  = '0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        pix   = img_q[8*((int'(row)+kr)*8+int'(col)+kc) +: 8];
        w     = ker_q[8*(kr*3+kc) +: 8];
        prod  = $signed({1'b0, pix}) * w;
        acc_d = acc_d + 21'(prod);
      end
    end
  end

  always_comb begin
    shv = acc_q >>> SHIFT;
`ifdef CONV_RELU_EN
    if (shv < 21'sd0)
      sat = 8'h00;
    else if (shv > 21'sd255)
      sat = 8'hff;
    else
      sat = shv[7:0];
`else
    if (shv < -21'sd128)
      sat = 8'h80;
    else if (shv > 21'sd127)
      sat = 8'h7f;
    else
      sat = shv[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      img_q       <= '0;
      ker_q       <= '0;
      bias_q      <= '0;
      idx         <= '0;
      s1_vld      <= 1'b0;
      s1_idx      <= '0;
      acc_q       <= '0;
      feature_out <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_vld  <= (state_q == CONV);
      if (start) begin
        img_q  <= image_in;
        ker_q  <= kernel_in;
        bias_q <= bias_in;
        idx    <= '0;
        busy   <= 1'b1;
        done   <= 1'b0;
      end else if (state_q == CONV) begin
        idx <= idx + 6'd1;
      end
      if (state_q == CONV) begin
        acc_q  <= acc_d;
        s1_idx <= idx;
      end
      if (s1_vld) begin
        feature_out[8*s1_idx +: 8] <= sat;
        if (s1_idx == 6'd35) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
